// File: rtl/trafficlight_pkg.sv
// Shared definitions for the intersection lights: aspect encodings, EW phase states and
// default phase lengths.
package trafficlight_pkg;

    localparam logic [3:0] LIGHT_LEFT   = 4'b1001;
    localparam logic [3:0] LIGHT_GREEN  = 4'b0100;
    localparam logic [3:0] LIGHT_YELLOW = 4'b0010;
    localparam logic [3:0] LIGHT_RED    = 4'b0001;

    localparam int unsigned LEFT_CYC_DEF   = 5;
    localparam int unsigned GREEN_CYC_DEF  = 9;
    localparam int unsigned YELLOW_CYC_DEF = 3;
    localparam int unsigned CNT_W_DEF      = 5;

    typedef enum logic [2:0] {
        StWait    = 3'd0,
        StLeft    = 3'd1,
        StGreen   = 3'd2,
        StYellow  = 3'd3,
        StAllStop = 3'd4
    } ew_state_e;

    // Go-phase sequence; anything past yellow falls back to waiting.
    function automatic ew_state_e next_phase(input ew_state_e s);
        case (s)
            StLeft:  return StGreen;
            StGreen: return StYellow;
            default: return StWait;
        endcase
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable phase up-counter: clear to zero, hold, or count; flags the last cycle of a phase.
module phase_timer #(
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             hold_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (!hold_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == (limit_i - CNT_W'(1)));

endmodule

// File: rtl/trafficlight_ew.sv
// East-West light: runs left/green/yellow once per NS-red rising edge, with emergency
// all-stop and a sticky interlock fault when NS leaves red during an EW go-phase.
module trafficlight_ew
    import trafficlight_pkg::*;
#(
    parameter int unsigned LEFT_CYC   = LEFT_CYC_DEF,
    parameter int unsigned GREEN_CYC  = GREEN_CYC_DEF,
    parameter int unsigned YELLOW_CYC = YELLOW_CYC_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       emergency,
    input  logic [3:0] ns_out,
    output logic [3:0] out,
    output logic       fault
);

    ew_state_e state_d, state_q, resume_d, resume_q;
    logic      pend_d, pend_q, fault_d, fault_q, ns_red_q;
    logic      ns_red, start, interlock, clr, hold, tc;
    logic [CNT_W-1:0] limit, cnt;

    assign ns_red    = (ns_out == LIGHT_RED);
    assign start     = ns_red & ~ns_red_q;
    assign interlock = (ns_out[3:1] != 3'b000) &&
                       (state_q inside {StLeft, StGreen, StYellow, StAllStop});

    always_comb begin
        case (state_q)
            StGreen:  limit = CNT_W'(GREEN_CYC);
            StYellow: limit = CNT_W'(YELLOW_CYC);
            default:  limit = CNT_W'(LEFT_CYC);
        endcase
    end

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_phase_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (clr),
        .hold_i  (hold),
        .limit_i (limit),
        .cnt_o   (cnt),
        .tc_o    (tc)
    );

    always_comb begin
        state_d  = state_q;
        resume_d = resume_q;
        pend_d   = pend_q;
        fault_d  = fault_q;
        clr      = 1'b0;
        hold     = 1'b1;
        if (interlock) begin
            state_d = StWait;
            pend_d  = 1'b0;
            fault_d = 1'b1;
            clr     = 1'b1;
        end else begin
            case (state_q)
                StWait: begin
                    clr = 1'b1;
                    if (!emergency && (start || pend_q)) begin
                        state_d = StLeft;
                        pend_d  = 1'b0;
                    end else if (start) begin
                        pend_d = 1'b1;
                    end
                end
                StLeft, StGreen, StYellow: begin
                    if (emergency) begin
                        // The cycle just shown still counts; only the terminal value is held.
                        state_d  = StAllStop;
                        resume_d = state_q;
                        hold     = tc;
                    end else if (tc) begin
                        state_d = next_phase(state_q);
                        clr     = 1'b1;
                    end else begin
                        hold = 1'b0;
                    end
                end
                StAllStop: begin
                    if (!emergency) begin
                        state_d = resume_q;
                    end
                end
                default: begin
                    state_d = StWait;
                    clr     = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StWait;
            resume_q <= StWait;
            pend_q   <= 1'b0;
            fault_q  <= 1'b0;
            ns_red_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            resume_q <= resume_d;
            pend_q   <= pend_d;
            fault_q  <= fault_d;
            ns_red_q <= ns_red;
        end
    end

    always_comb begin
        case (state_q)
            StLeft:   out = LIGHT_LEFT;
            StGreen:  out = LIGHT_GREEN;
            StYellow: out = LIGHT_YELLOW;
            default:  out = LIGHT_RED;
        endcase
    end

    assign fault = fault_q;

endmodule

// File: tb/tb_trafficlight_ew.sv
// Randomized and directed bench for trafficlight_ew against a remaining-cycles phase model.
module tb_trafficlight_ew;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       emergency;
    logic [3:0] ns_out;
    logic [3:0] out;
    logic       fault;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: phase 0 wait, 1 left, 2 green, 3 yellow; m_remain counts cycles still owed.
    int m_phase;
    int m_remain;
    bit m_allstop, m_pend, m_fault, m_prev_red;

    trafficlight_ew dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .emergency (emergency),
        .ns_out    (ns_out),
        .out       (out),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got %b expected %b", tag, $time, obs, exp);
        end
    endtask

    function automatic int phase_len(input int p);
        case (p)
            1:       return 5;
            2:       return 9;
            default: return 3;
        endcase
    endfunction

    function automatic logic [3:0] model_out();
        if (m_allstop) return 4'b0001;
        case (m_phase)
            1:       return 4'b1001;
            2:       return 4'b0100;
            3:       return 4'b0010;
            default: return 4'b0001;
        endcase
    endfunction

    task automatic model_reset();
        m_phase    = 0;
        m_remain   = 0;
        m_allstop  = 0;
        m_pend     = 0;
        m_fault    = 0;
        m_prev_red = 1;
    endtask

    task automatic model_step(input logic [3:0] ns, input logic emg);
        bit red   = (ns == 4'b0001);
        bit start = red && !m_prev_red;
        bit go    = m_allstop || (m_phase != 0);
        if (go && (ns[3:1] != 3'b000)) begin
            m_phase   = 0;
            m_allstop = 0;
            m_pend    = 0;
            m_fault   = 1;
        end else if (m_allstop) begin
            if (!emg) m_allstop = 0;
        end else if (m_phase != 0) begin
            if (emg) begin
                m_allstop = 1;
                if (m_remain > 1) m_remain--;
            end else if (m_remain == 1) begin
                m_phase  = (m_phase == 3) ? 0 : m_phase + 1;
                m_remain = phase_len(m_phase);
            end else begin
                m_remain--;
            end
        end else begin
            if (!emg && (start || m_pend)) begin
                m_phase  = 1;
                m_remain = phase_len(1);
                m_pend   = 0;
            end else if (start) begin
                m_pend = 1;
            end
        end
        m_prev_red = red;
    endtask

    // Called at a falling edge: drive, clock, then compare at the next falling edge.
    task automatic cycle(input logic [3:0] ns, input logic emg);
        ns_out    = ns;
        emergency = emg;
        @(posedge clk);
        model_step(ns, emg);
        @(negedge clk);
        check_eq("out", out, model_out());
        check_eq("fault", {3'b000, fault}, {3'b000, m_fault});
    endtask

    task automatic run(input logic [3:0] ns, input logic emg, input int n);
        for (int i = 0; i < n; i++) cycle(ns, emg);
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_eq("rst_out_async", out, 4'b0001);
        check_eq("rst_fault_async", {3'b000, fault}, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] ns_r;
        int r;
        rst_n     = 1'b1;
        emergency = 1'b0;
        ns_out    = 4'b1001;
        model_reset();
        #1 rst_n = 1'b0;
        #1;
        check_eq("rst_out", out, 4'b0001);
        check_eq("rst_fault", {3'b000, fault}, 4'b0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Normal cycle.
        run(4'b1001, 0, 5);
        run(4'b0100, 0, 10);
        run(4'b0010, 0, 3);
        run(4'b0001, 0, 18);
        // Single emergency pulse mid-green.
        run(4'b0010, 0, 2);
        run(4'b0001, 0, 10);
        run(4'b0001, 1, 1);
        run(4'b0001, 0, 20);
        // Held emergency during left.
        run(4'b0010, 0, 2);
        run(4'b0001, 0, 3);
        run(4'b0001, 1, 4);
        run(4'b0001, 0, 20);
        // Emergency coinciding with the left terminal count.
        run(4'b0010, 0, 1);
        run(4'b0001, 0, 5);
        run(4'b0001, 1, 1);
        run(4'b0001, 0, 20);
        // Start edge during emergency.
        run(4'b0010, 0, 2);
        run(4'b0001, 1, 2);
        run(4'b0001, 0, 20);
        // Interlock during green, then restart with fault still set.
        run(4'b0010, 0, 2);
        run(4'b0001, 0, 8);
        run(4'b0100, 0, 2);
        run(4'b0001, 0, 20);
        // Async reset mid-yellow; no start without a fresh edge.
        run(4'b0010, 0, 2);
        run(4'b0001, 0, 15);
        async_reset();
        run(4'b0001, 0, 6);
        run(4'b0010, 0, 1);
        run(4'b0001, 0, 20);

        // Randomized traffic with occasional emergencies, violations and resets.
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 70)      ns_r = 4'b0001;
            else if (r < 82) ns_r = 4'b0010;
            else if (r < 87) ns_r = 4'b1001;
            else if (r < 90) ns_r = 4'b0100;
            else if (r < 93) ns_r = 4'($urandom_range(0, 15));
            else             ns_r = 4'b0001;
            cycle(ns_r, ($urandom_range(0, 14) == 0));
            if ((i % 500) == 499) async_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
